// File: rtl/qdec_cabac_package.sv
// Shared types and constants for the CABAC decoder front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package qdec_cabac_package;

    // Bitstream feeder sequencing states
    typedef enum logic [1:0] {
        BSF_IDLE  = 2'd0,
        BSF_FETCH = 2'd1,
        BSF_DRAIN = 2'd2,
        BSF_DONE  = 2'd3
    } t_bsf_state_e;

    // Third byte of an HEVC emulation-prevention sequence (00 00 03)
    localparam logic [7:0] EPB_BYTE = 8'h03;

endpackage

// File: rtl/basic_fifo.sv
// Generic show-ahead FIFO; head word visible on rd_data while not empty.
// Latency: a write is visible at the head one cycle later.
// Backpressure: writes refused when full unless a read happens the same cycle.
module basic_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  empty,
    output logic                  full
);

    logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];
    logic [ADDR_WIDTH-1:0] wptr_q;
    logic [ADDR_WIDTH-1:0] rptr_q;
    logic [ADDR_WIDTH:0]   cnt_q;
    logic                  do_wr;
    logic                  do_rd;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (ADDR_WIDTH+1)'(DATA_DEPTH));
    assign count   = cnt_q;
    assign rd_data = mem_q[rptr_q];
    assign do_rd   = rd_en && !empty;
    // A full FIFO may still accept a word when the head leaves in the same cycle
    assign do_wr   = wr_en && (!full || do_rd);

    // Storage array, no reset needed: entries are only read when counted valid
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wptr_q] <= wr_data;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_wr) begin
                wptr_q <= wptr_q + ADDR_WIDTH'(1);
            end
            if (do_rd) begin
                rptr_q <= rptr_q + ADDR_WIDTH'(1);
            end
            if (do_wr && !do_rd) begin
                cnt_q <= cnt_q + (ADDR_WIDTH+1)'(1);
            end else if (do_rd && !do_wr) begin
                cnt_q <= cnt_q - (ADDR_WIDTH+1)'(1);
            end
        end
    end

endmodule

// File: rtl/qdec_bs_feeder.sv
// Reads a byte range from bitstream RAM, strips 00 00 03 emulation bytes, streams to CABAC.
// Latency: start -> mem_re +1 cycle -> first valid byte +3 cycles; 1 byte/cycle sustained.
// Backpressure: reads are credit-limited so FIFO occupancy plus the in-flight byte never exceeds depth.
module qdec_bs_feeder
    import qdec_cabac_package::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int EPB_REMOVE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   byte_len,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           epb_cnt,
    output logic                  mem_re,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    input  logic [7:0]            mem_rdata,
    output logic [7:0]            bitstreamFetch,
    output logic                  bitstreamFetch_vld,
    input  logic                  bitstreamFetch_rdy
);

    localparam int FA = $clog2(FIFO_DEPTH);

    t_bsf_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   remain_q, remain_d;
    logic [1:0]            zero_cnt_q, zero_cnt_d;
    logic [15:0]           epb_cnt_q, epb_cnt_d;
    logic                  inflight_q;

    logic [FA:0]           fifo_count;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [7:0]            fifo_rdata;
    logic [FA+1:0]         credit;
    logic                  issue;
    logic                  pop;
    logic                  push;
    logic                  is_epb;

    // Credit counts the byte still in the RAM pipeline so its slot is always reserved
    assign credit = {1'b0, fifo_count} + (FA+2)'(inflight_q);
    assign issue  = (state_q == BSF_FETCH) && (remain_q != '0) &&
                    (credit < (FA+2)'(FIFO_DEPTH));
    assign pop    = !fifo_empty && bitstreamFetch_rdy;
    assign is_epb = (EPB_REMOVE != 0) && (zero_cnt_q == 2'd2) && (mem_rdata == EPB_BYTE);
    assign push   = inflight_q && !is_epb;

    assign busy               = (state_q == BSF_FETCH) || (state_q == BSF_DRAIN);
    assign done               = (state_q == BSF_DONE);
    assign epb_cnt            = epb_cnt_q;
    assign mem_re             = issue;
    assign mem_raddr          = addr_q;
    assign bitstreamFetch_vld = !fifo_empty;
    assign bitstreamFetch     = fifo_empty ? 8'h00 : fifo_rdata;

    // Next-state: sequencing, address/length bookkeeping and the emulation-byte filter
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        remain_d   = remain_q;
        zero_cnt_d = zero_cnt_q;
        epb_cnt_d  = epb_cnt_q;

        if (inflight_q) begin
            if (is_epb) begin
                zero_cnt_d = 2'd0;
                if (epb_cnt_q != 16'hFFFF) begin
                    epb_cnt_d = epb_cnt_q + 16'd1;
                end
            end else if (mem_rdata == 8'h00) begin
                zero_cnt_d = (zero_cnt_q == 2'd2) ? 2'd2 : zero_cnt_q + 2'd1;
            end else begin
                zero_cnt_d = 2'd0;
            end
        end

        case (state_q)
            BSF_IDLE: begin
                if (start) begin
                    addr_d     = base_addr;
                    remain_d   = byte_len;
                    zero_cnt_d = 2'd0;
                    epb_cnt_d  = 16'd0;
                    state_d    = (byte_len == '0) ? BSF_DONE : BSF_FETCH;
                end
            end
            BSF_FETCH: begin
                if (issue) begin
                    addr_d   = addr_q + ADDR_WIDTH'(1);
                    remain_d = remain_q - (ADDR_WIDTH+1)'(1);
                    if (remain_q == (ADDR_WIDTH+1)'(1)) begin
                        state_d = BSF_DRAIN;
                    end
                end
            end
            BSF_DRAIN: begin
                // Finish as soon as the last byte leaves, counting a pop in this cycle
                if (!inflight_q && (fifo_empty || (fifo_count == (FA+1)'(1) && pop))) begin
                    state_d = BSF_DONE;
                end
            end
            BSF_DONE: begin
                state_d = BSF_IDLE;
            end
            default: begin
                state_d = BSF_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any run and the byte still in the RAM pipeline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= BSF_IDLE;
            addr_q     <= '0;
            remain_q   <= '0;
            zero_cnt_q <= 2'd0;
            epb_cnt_q  <= 16'd0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            zero_cnt_q <= zero_cnt_d;
            epb_cnt_q  <= epb_cnt_d;
            inflight_q <= issue;
        end
    end

    basic_fifo #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (FA),
        .DATA_DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (mem_rdata),
        .rd_en   (pop),
        .rd_data (fifo_rdata),
        .count   (fifo_count),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

endmodule

// File: tb/tb_qdec_bs_feeder.sv
// Scoreboard bench: two feeders (EPB strip on / off) share stimulus and RAM image.
// Latency: checks first byte, last byte and done cycles against the start cycle.
// Backpressure: stalls the consumer and checks the head byte stays stable.
module tb_qdec_bs_feeder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] base_addr = '0;
    logic [16:0] byte_len = '0;
    logic        rdy = 1'b1;

    logic        busy, done, mem_re, vld;
    logic [15:0] epb_cnt, mem_raddr;
    logic [7:0]  mem_rdata, bs;
    logic        busy_p, done_p, mem_re_p, vld_p;
    logic [15:0] epb_cnt_p, mem_raddr_p;
    logic [7:0]  mem_rdata_p, bs_p;

    logic [7:0]  ram [0:65535];
    logic [7:0]  q_exp[$];
    logic [7:0]  q_exp_p[$];
    logic [15:0] q_addr[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int first_vld, last_vld, done_rel, done_cnt, done_cnt_p, re_cnt;
    int exp_epb;
    bit prev_stall = 1'b0;
    logic [7:0] prev_byte;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    qdec_bs_feeder #(.ADDR_WIDTH(16), .FIFO_DEPTH(4), .EPB_REMOVE(1)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .byte_len(byte_len),
        .busy(busy), .done(done), .epb_cnt(epb_cnt), .mem_re(mem_re), .mem_raddr(mem_raddr),
        .mem_rdata(mem_rdata), .bitstreamFetch(bs), .bitstreamFetch_vld(vld),
        .bitstreamFetch_rdy(rdy)
    );

    qdec_bs_feeder #(.ADDR_WIDTH(16), .FIFO_DEPTH(4), .EPB_REMOVE(0)) dut_pass (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .byte_len(byte_len),
        .busy(busy_p), .done(done_p), .epb_cnt(epb_cnt_p), .mem_re(mem_re_p),
        .mem_raddr(mem_raddr_p), .mem_rdata(mem_rdata_p), .bitstreamFetch(bs_p),
        .bitstreamFetch_vld(vld_p), .bitstreamFetch_rdy(rdy)
    );

    // Synchronous RAM models, data one cycle after the read enable
    always @(posedge clk) begin
        if (mem_re)   mem_rdata   <= ram[mem_raddr];
        if (mem_re_p) mem_rdata_p <= ram[mem_raddr_p];
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Output monitor: pops the scoreboards and records event cycles
    always @(negedge clk) begin
        int rel;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            rel = cyc - start_cyc;
            if (prev_stall) begin
                chk("stall_vld", 32'(vld), 32'd1);
                chk("stall_byte", 32'(bs), 32'(prev_byte));
            end
            if (vld && rdy) begin
                if (q_exp.size() == 0) chk("extra_byte", 32'd1, 32'd0);
                else chk("byte", 32'(bs), 32'(q_exp.pop_front()));
                if (first_vld < 0) first_vld = rel;
                last_vld = rel;
            end
            if (vld_p && rdy) begin
                if (q_exp_p.size() == 0) chk("extra_byte_pass", 32'd1, 32'd0);
                else chk("byte_pass", 32'(bs_p), 32'(q_exp_p.pop_front()));
            end
            if (mem_re) begin
                re_cnt++;
                if (q_addr.size() == 0) chk("extra_read", 32'd1, 32'd0);
                else chk("raddr", 32'(mem_raddr), 32'(q_addr.pop_front()));
            end
            if (done) begin
                done_cnt++;
                done_rel = rel;
            end
            if (done_p) done_cnt_p++;
            prev_stall = vld && !rdy;
            prev_byte  = bs;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load RAM and push expected bytes/addresses for both feeders
    task automatic setup(input logic [15:0] base, input logic [7:0] d[$]);
        int zc = 0;
        exp_epb = 0;
        for (int i = 0; i < d.size(); i++) begin
            logic [15:0] a;
            a = base + 16'(i);
            ram[a] = d[i];
            q_addr.push_back(a);
            q_exp_p.push_back(d[i]);
            if (zc == 2 && d[i] == 8'h03) begin
                zc = 0;
                exp_epb++;
            end else begin
                q_exp.push_back(d[i]);
                zc = (d[i] == 8'h00) ? ((zc == 2) ? 2 : zc + 1) : 0;
            end
        end
    endtask

    task automatic go(input logic [15:0] base, input logic [16:0] len);
        first_vld = -1; last_vld = -1; done_rel = -1;
        done_cnt = 0; done_cnt_p = 0; re_cnt = 0;
        start_cyc = cyc;
        base_addr = base;
        byte_len  = len;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!(done_cnt > 0 && done_cnt_p > 0) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) begin
            n_checks++;
            n_errors++;
            $display("FAIL timeout: no done within %0d cycles", budget);
        end
        tick();
        tick();
    endtask

    task automatic sb_empty(input string tag);
        chk({tag, "_sb"}, 32'(q_exp.size()), 32'd0);
        chk({tag, "_sb_pass"}, 32'(q_exp_p.size()), 32'd0);
        chk({tag, "_sb_addr"}, 32'(q_addr.size()), 32'd0);
    endtask

    initial begin
        logic [7:0] d[$];

        // Reset state
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_re", 32'(mem_re), 32'd0);
        chk("rst_vld", 32'(vld), 32'd0);
        chk("rst_epb", 32'(epb_cnt), 32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Plain bytes, latency and throughput
        d = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        setup(16'h0010, d);
        go(16'h0010, 17'(d.size()));
        wait_done(100);
        chk("t1_first_vld", 32'(first_vld), 32'd3);
        chk("t1_last_vld", 32'(last_vld), 32'd10);
        chk("t1_done_cyc", 32'(done_rel), 32'd11);
        chk("t1_done_cnt", 32'(done_cnt), 32'd1);
        chk("t1_epb", 32'(epb_cnt), 32'(exp_epb));
        sb_empty("t1");

        // Single emulation-prevention byte
        d = '{8'h00, 8'h00, 8'h03, 8'h01, 8'h25};
        setup(16'h0100, d);
        go(16'h0100, 17'(d.size()));
        wait_done(100);
        chk("t2_epb", 32'(epb_cnt), 32'(exp_epb));
        chk("t2_epb_pass", 32'(epb_cnt_p), 32'd0);
        chk("t2_done_cnt", 32'(done_cnt), 32'd1);
        sb_empty("t2");

        // Back-to-back 03 and a second sequence
        d = '{8'h00, 8'h00, 8'h03, 8'h03, 8'h00, 8'h00, 8'h03, 8'h00};
        setup(16'h0200, d);
        go(16'h0200, 17'(d.size()));
        wait_done(100);
        chk("t3_epb", 32'(epb_cnt), 32'd2);
        chk("t3_epb_pass", 32'(epb_cnt_p), 32'd0);
        sb_empty("t3");

        // Consumer stall: credit limit and stable head byte
        d.delete();
        for (int i = 0; i < 20; i++) d.push_back(8'(i * 13 + 5));
        setup(16'h0300, d);
        go(16'h0300, 17'(d.size()));
        tick(); tick();
        rdy = 1'b0;
        repeat (13) tick();
        chk("t4_reads_stalled", 32'(re_cnt), 32'd4);
        rdy = 1'b1;
        wait_done(200);
        chk("t4_reads", 32'(re_cnt), 32'd20);
        sb_empty("t4");

        // Zero length
        d.delete();
        setup(16'h0400, d);
        go(16'h0400, 17'd0);
        wait_done(50);
        chk("t5_done_cyc", 32'(done_rel), 32'd1);
        chk("t5_reads", 32'(re_cnt), 32'd0);

        // Start while busy is ignored
        d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        setup(16'h0500, d);
        go(16'h0500, 17'(d.size()));
        tick(); tick(); tick();
        base_addr = 16'h0900;
        byte_len  = 17'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(100);
        repeat (6) tick();
        chk("t5_done_once", 32'(done_cnt), 32'd1);
        chk("t5_reads8", 32'(re_cnt), 32'd8);
        sb_empty("t5");

        // Address wrap
        d = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        setup(16'hFFFE, d);
        go(16'hFFFE, 17'd4);
        wait_done(100);
        chk("t6_reads", 32'(re_cnt), 32'd4);
        sb_empty("t6");

        // Reset mid-run, then a clean run
        d.delete();
        for (int i = 0; i < 16; i++) d.push_back(8'(8'h40 + i));
        setup(16'h0600, d);
        go(16'h0600, 17'd16);
        repeat (4) tick();
        chk("t7_busy_run", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("t7_vld", 32'(vld), 32'd0);
        chk("t7_vld_pass", 32'(vld_p), 32'd0);
        chk("t7_busy", 32'(busy), 32'd0);
        chk("t7_done", 32'(done), 32'd0);
        chk("t7_re", 32'(mem_re), 32'd0);
        tick(); tick();
        q_exp.delete(); q_exp_p.delete(); q_addr.delete();
        rst = 1'b0;
        tick();
        d = '{8'h5A, 8'h00, 8'h00, 8'h03};
        setup(16'h0700, d);
        go(16'h0700, 17'd4);
        wait_done(100);
        chk("t7_first_vld", 32'(first_vld), 32'd3);
        chk("t7_done_cnt", 32'(done_cnt), 32'd1);
        chk("t7_reads", 32'(re_cnt), 32'd4);
        chk("t7_epb", 32'(epb_cnt), 32'd1);
        sb_empty("t7");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
